// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the byte-enable merge used by both the storage update and the bypass path.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NBYTES     = DEF_DATA_W / 8;

  // Selects the new byte when its enable is set, otherwise keeps the old one.
  // Chaining two calls (A then B) gives the B-over-A-over-stored merge.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: selects the stored word, overlays any
// same-cycle write bytes when bypass is on, forces register 0 to zero and
// masks the busy bit when the pending producer is writing back this cycle.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     mem [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  busy_vec,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W/8-1:0]   wa_be,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W/8-1:0]   wb_be,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [DATA_W-1:0]     data,
  output logic                  busy
);

  logic              is_zero;
  logic              a_hit;
  logic              b_hit;
  logic              r_hit;
  logic [DATA_W-1:0] stored;

  // Read mux with optional byte-wise forwarding and busy masking.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr == '0);
    a_hit   = (BYPASS != 0) && wa_en && (wa_addr == addr);
    b_hit   = (BYPASS != 0) && wb_en && (wb_addr == addr);
    r_hit   = rsv_en && (rsv_addr == addr);
    stored  = mem[addr];
    data    = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      data[b*8 +: 8] = merge_byte(merge_byte(stored[b*8 +: 8], wa_data[b*8 +: 8],
                                             a_hit && wa_be[b]),
                                  wb_data[b*8 +: 8], b_hit && wb_be[b]);
    end
    if (is_zero) begin
      data = '0;
    end
    busy = busy_vec[addr] && !((a_hit || b_hit) && !r_hit);
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD combinational read ports, two
// byte-enabled write ports (B wins per byte on a shared address), optional
// hardwired zero register and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W/8-1:0]        wa_be,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W/8-1:0]        wb_be,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [2**ADDR_W-1:0]       busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;
  logic              a_ok;
  logic              b_ok;
  logic              wa_fwd;
  logic              wb_fwd;

  assign busy_vec = busy_q;

  // Forwarding is suppressed while reset is held so reads stay at zero.
  assign wa_fwd = wa_en && rst_n;
  assign wb_fwd = wb_en && rst_n;

  // Next storage contents: drop writes to r0, then merge A and B byte-wise.
  always_comb begin
    a_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
    b_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));
    for (int k = 0; k < DEPTH; k++) begin
      mem_next[k] = mem[k];
      for (int b = 0; b < DATA_W / 8; b++) begin
        mem_next[k][b*8 +: 8] =
          merge_byte(merge_byte(mem[k][b*8 +: 8], wa_data[b*8 +: 8],
                                a_ok && (wa_addr == ADDR_W'(k)) && wa_be[b]),
                     wb_data[b*8 +: 8],
                     b_ok && (wb_addr == ADDR_W'(k)) && wb_be[b]);
      end
    end
  end

  // Next scoreboard: writes clear, a same-cycle reserve re-sets (new producer wins).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      busy_next[k] = (busy_q[k] && !((wa_en && (wa_addr == ADDR_W'(k))) ||
                                     (wb_en && (wb_addr == ADDR_W'(k)))))
                     || (rsv_en && (rsv_addr == ADDR_W'(k)));
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  // Storage and scoreboard registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem    <= mem_next;
      busy_q <= busy_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem     (mem),
      .busy_vec(busy_q),
      .wa_en   (wa_fwd),
      .wa_addr (wa_addr),
      .wa_be   (wa_be),
      .wa_data (wa_data),
      .wb_en   (wb_fwd),
      .wb_addr (wb_addr),
      .wb_be   (wb_be),
      .wb_data (wb_data),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
      .data    (rd_data[k*DATA_W +: DATA_W]),
      .busy    (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing instance and a
// non-bypassing instance share one stimulus stream; each vector carries its
// own hand-derived expected outputs, queued at drive time and popped at check.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR*AW-1:0]    rd_addr = '0;
  logic [NR*DW-1:0]    rd_data, rd_data_nb;
  logic [NR-1:0]       rd_busy, rd_busy_nb;
  logic                wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0]       wa_addr = '0, wb_addr = '0, rsv_addr = '0;
  logic [NBYTES-1:0]   wa_be = '0, wb_be = '0;
  logic [DW-1:0]       wa_data = '0, wb_data = '0;
  logic [2**AW-1:0]    busy_vec, busy_vec_nb;

  typedef struct {
    logic [NR*AW-1:0]  ra;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [NBYTES-1:0] wa_be;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [NBYTES-1:0] wb_be;
    logic [DW-1:0]     wb_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NR*DW-1:0]  exp_data;
    logic [DW-1:0]     exp_nb0;
    logic [NR-1:0]     exp_busy;
    logic [31:0]       exp_bv;
  } vec_t;

  typedef struct {
    int                id;
    logic [AW-1:0]     a0;
    logic [NR*DW-1:0]  data;
    logic [DW-1:0]     nb0;
    logic [NR-1:0]     busy;
    logic [31:0]       bv;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_be(wa_be), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_be(wb_be), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_be(wa_be), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_be(wb_be), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_nb)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int wae, input int waa, input int wab, input logic [31:0] wad,
                              input int wbe, input int wba, input int wbb, input logic [31:0] wbd,
                              input int rse, input int rsa,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [31:0] enb, input int eb, input logic [31:0] ebv);
    vec_t v;
    v.ra       = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    v.wa_en    = (wae != 0);
    v.wa_addr  = AW'(waa);
    v.wa_be    = NBYTES'(wab);
    v.wa_data  = wad;
    v.wb_en    = (wbe != 0);
    v.wb_addr  = AW'(wba);
    v.wb_be    = NBYTES'(wbb);
    v.wb_data  = wbd;
    v.rsv_en   = (rse != 0);
    v.rsv_addr = AW'(rsa);
    v.exp_data = {e3, e2, e1, e0};
    v.exp_nb0  = enb;
    v.exp_busy = NR'(eb);
    v.exp_bv   = ebv;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rd_addr  = v.ra;
    wa_en    = v.wa_en;   wa_addr = v.wa_addr; wa_be = v.wa_be; wa_data = v.wa_data;
    wb_en    = v.wb_en;   wb_addr = v.wb_addr; wb_be = v.wb_be; wb_data = v.wb_data;
    rsv_en   = v.rsv_en;  rsv_addr = v.rsv_addr;
    e.id     = vec_id;
    e.a0     = v.ra[AW-1:0];
    e.data   = v.exp_data;
    e.nb0    = v.exp_nb0;
    e.busy   = v.exp_busy;
    e.bv     = v.exp_bv;
    sb.push_back(e);
    vec_id++;
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, id, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < NR; k++) begin
      cmp($sformatf("rd_data%0d", k), e.id, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
    end
    cmp("rd_busy", e.id, 32'(rd_busy), 32'(e.busy));
    cmp("busy_vec", e.id, busy_vec, e.bv);
    cmp("nb_rd_data0", e.id, rd_data_nb[DW-1:0], e.nb0);
    cmp("nb_rd_busy0", e.id, 32'(rd_busy_nb[0]), 32'(e.bv[e.a0]));
    cmp("nb_busy_vec", e.id, busy_vec_nb, e.bv);
  endtask

  initial begin
    // addr0..3 | wa en,addr,be,data | wb en,addr,be,data | rsv en,addr | exp data0..3 | nb0 | busy | busy_vec
    tbl.push_back(mk(3,0,0,0, 1,3,4'hF,32'h11223344, 0,0,0,0, 0,0, 32'h11223344,0,0,0, 0, 4'b0000, 0));
    tbl.push_back(mk(3,3,0,0, 1,3,4'hF,32'hAAAAAAAA, 1,3,4'b0101,32'hBBBBBBBB, 0,0,
                     32'hAABBAABB,32'hAABBAABB,0,0, 32'h11223344, 4'b0000, 0));
    tbl.push_back(mk(3,3,9,0, 0,0,0,0, 0,0,0,0, 1,9, 32'hAABBAABB,32'hAABBAABB,0,0, 32'hAABBAABB, 4'b0000, 0));
    tbl.push_back(mk(9,3,0,9, 0,0,0,0, 0,0,0,0, 0,0, 0,32'hAABBAABB,0,0, 0, 4'b1001, 32'h200));
    tbl.push_back(mk(9,9,3,0, 0,0,0,0, 1,9,4'hF,32'hCAFEF00D, 0,0,
                     32'hCAFEF00D,32'hCAFEF00D,32'hAABBAABB,0, 0, 4'b0000, 32'h200));
    tbl.push_back(mk(9,9,3,0, 1,9,4'b0011,32'h00001234, 0,0,0,0, 1,9,
                     32'hCAFE1234,32'hCAFE1234,32'hAABBAABB,0, 32'hCAFEF00D, 4'b0000, 0));
    tbl.push_back(mk(9,5,3,0, 1,5,4'b0000,32'h55555555, 0,0,0,0, 0,0,
                     32'hCAFE1234,0,32'hAABBAABB,0, 32'hCAFE1234, 4'b0001, 32'h200));
    tbl.push_back(mk(9,12,3,0, 1,9,4'b0000,32'hFFFFFFFF, 0,0,0,0, 1,12,
                     32'hCAFE1234,0,32'hAABBAABB,0, 32'hCAFE1234, 4'b0000, 32'h200));
    tbl.push_back(mk(0,12,9,3, 1,0,4'hF,32'hFFFFFFFF, 0,0,0,0, 1,0,
                     0,0,32'hCAFE1234,32'hAABBAABB, 0, 4'b0010, 32'h1000));
    tbl.push_back(mk(7,12,0,9, 1,7,4'hF,32'h12345678, 0,0,0,0, 0,0,
                     32'h12345678,0,0,32'hCAFE1234, 0, 4'b0010, 32'h1000));
    tbl.push_back(mk(7,3,9,0, 0,0,0,0, 0,0,0,0, 0,0,
                     32'h12345678,32'hAABBAABB,32'hCAFE1234,0, 32'h12345678, 4'b0000, 32'h1000));
    tbl.push_back(mk(3,7,9,12, 0,0,0,0, 1,12,4'hF,32'h0BADC0DE, 0,0,
                     32'hAABBAABB,32'h12345678,32'hCAFE1234,32'h0BADC0DE, 32'hAABBAABB, 4'b0000, 32'h1000));
    tbl.push_back(mk(12,12,7,3, 0,0,0,0, 0,0,0,0, 0,0,
                     32'h0BADC0DE,32'h0BADC0DE,32'h12345678,32'hAABBAABB, 32'h0BADC0DE, 4'b0000, 0));

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    applyStimulus(mk(3,9,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0, 4'b0000, 0));
    #2;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #2;
      checkOutput();
    end

    $display("[TB] asynchronous reset mid-run");
    @(negedge clk);
    applyStimulus(mk(5,6,0,0, 1,5,4'hF,32'hDEADBEEF, 0,0,0,0, 1,6, 32'hDEADBEEF,0,0,0, 0, 4'b0000, 0));
    #2;
    checkOutput();
    @(negedge clk);
    applyStimulus(mk(5,6,0,0, 0,0,0,0, 0,0,0,0, 0,0, 32'hDEADBEEF,0,0,0, 32'hDEADBEEF, 4'b0010, 32'h40));
    #2;
    checkOutput();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    applyStimulus(mk(5,6,3,0, 1,5,4'hF,32'hFFFFFFFF, 0,0,0,0, 1,6, 0,0,0,0, 0, 4'b0000, 0));
    #1;
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(5,3,6,0, 1,5,4'b0011,32'h01020304, 0,0,0,0, 0,0, 32'h00000304,0,0,0, 0, 4'b0000, 0));
    #2;
    checkOutput();
    @(negedge clk);
    applyStimulus(mk(5,3,6,0, 0,0,0,0, 0,0,0,0, 0,0, 32'h00000304,0,0,0, 32'h00000304, 4'b0000, 0));
    #2;
    checkOutput();

    cmp("scoreboard_drained", vec_id, 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the 32x32 two-read/one-write file in the CPU datapath.
- Adds the following:
  - configurable width, depth and read-port count
  - two write ports with per-byte enables
  - optional hardwired-zero register 0
  - write-to-read bypass
  - per-register busy scoreboard for pipeline hazard detection
- Sits between decode (reads, reservations) and writeback/memory-return (writes).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never goes busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address, combinational.
- wa_en  in  1  write port A enable (writeback path).
- wa_addr  in  ADDR_W  port A address.
- wa_be  in  DATA_W/8  port A byte enables.
- wa_data  in  DATA_W  port A data.
- wb_en  in  1  write port B enable (memory-return path).
- wb_addr  in  ADDR_W  port B address.
- wb_be  in  DATA_W/8  port B byte enables.
- wb_data  in  DATA_W  port B data.
- rsv_en  in  1  reserve: mark rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  2**ADDR_W  full scoreboard, registered.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all registers cleared to 0 and all busy bits cleared.
  - rd_data therefore reads 0 and rd_busy reads 0 while reset is held.
  - Reset mid-write discards the write. Release is synchronous to the next clk edge.
- Writes:
  - Committed on the rising clk edge; only bytes with be[i]=1 are updated.
  - wa_en/wb_en with all be=0 change no data but still clear busy.
- Same-address conflict: if wa_en and wb_en target the same address in one cycle:
  - per byte, B has priority where wb_be[i]=1, otherwise A's byte applies where wa_be[i]=1.
  - This is a merge, not whole-word priority.
- Reads:
  - Combinational, latency 0 from rd_addr.
  - With BYPASS=1, rd_data per byte = the merged value of any same-cycle write (B over A over stored) to that address.
  - With BYPASS=0, rd_data returns the stored value; the new value is visible the cycle after the edge.
- ZERO_REG=1:
  - Address 0 always reads 0 and bypass is not applied.
  - Writes to address 0 are dropped.
  - rsv to address 0 is ignored; busy_vec[0] is always 0.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - Any enabled write (A or B) clears busy[addr] at the edge.
  - Same-cycle reserve and write to the same address leave busy=1: the new producer wins.
  - A write to a non-busy register is legal and leaves it 0.
- rd_busy:
  - Reflects registered busy_vec[rd_addr].
  - With BYPASS=1, it is masked to 0 if a same-cycle write targets that address and no same-cycle rsv does, so a consumer may issue in the writeback cycle.
- No X propagation: out-of-range addresses cannot occur because depth = 2**ADDR_W.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W constants
  - a function for byte-enable merge (old, new, be)
  - localparam NBYTES = DATA_W/8
- One natural sub-module: regfile_rd_port. It handles a single read port (address decode, zero gating, bypass mux, busy masking) and is instantiated NUM_RD times in a generate loop.
- Storage and scoreboard live in the top level.

Test Plan:
- Reset:
  - Write 0xDEADBEEF to r5, reserve r6, then pulse rst_n low between edges.
  - Required: rd_data of r5 is 0 immediately (asynchronously), busy_vec = 0, and the first write after release succeeds.
- Byte merge conflict:
  - r3=0x11223344; same cycle wa: addr 3, be=4'b1111, data 0xAAAAAAAA; wb: addr 3, be=4'b0101, data 0xBBBBBBBB.
  - Required: r3 = 0xAABBAABB.
- Bypass:
  - BYPASS=1, rd_addr0=7, wa writes 0x12345678 to r7 with full be.
  - Required: rd_data0 = 0x12345678 in the same cycle.
  - With BYPASS=0, the old value is returned that cycle and the new value the next.
- Zero register:
  - wa writes 0xFFFFFFFF to r0 and rsv r0.
  - Required: rd_data reads 0, busy_vec[0]=0, and with bypass active the read stays 0.
- Scoreboard:
  - rsv r9 -> busy_vec[9]=1 next cycle and rd_busy=1 when reading r9.
  - wb write r9 -> busy clears after the edge, and rd_busy=0 in the write cycle (bypass).
  - Same-cycle rsv r9 and wa r9 -> busy stays 1.
- Multi-port read: NUM_RD=4, all ports on different registers plus two ports on the same register -> each port returns its own correct value independently.
